// File: rtl/dft_mag_feeder.sv
// dft_mag_feeder: turns a stream of signed complex DFT bins into power words
// (re^2 + im^2) and feeds them one at a time to a non-pipelined sqrt unit.
// Each bin index travels with its power word so that downstream logic can
// pair every sqrt result with the bin it belongs to.

module dft_mag_feeder #(
    parameter int IN_W       = 16,
    parameter int IDX_W      = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IN_W-1:0]     in_re,
    input  logic [IN_W-1:0]     in_im,
    input  logic [IDX_W-1:0]    in_idx,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [2*IN_W-1:0]   sqrt_data,
    output logic                sqrt_valid,
    input  logic                sqrt_done,
    output logic [IDX_W-1:0]    out_idx,
    output logic                out_valid,
    output logic                drop
);

    localparam int P_W   = 2 * IN_W;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state;

    logic                s0_valid;
    logic [IN_W-1:0]     s0_re;
    logic [IN_W-1:0]     s0_im;
    logic [IDX_W-1:0]    s0_idx;

    logic                s1_valid;
    logic [P_W-1:0]      s1_re_sq;
    logic [P_W-1:0]      s1_im_sq;
    logic [IDX_W-1:0]    s1_idx;

    logic [P_W-1:0]      fifo_data [FIFO_DEPTH];
    logic [IDX_W-1:0]    fifo_tag  [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    fifo_count;

    logic [IDX_W-1:0]    cur_tag;

    logic signed [P_W-1:0] re_ext;
    logic signed [P_W-1:0] im_ext;
    logic [P_W-1:0]      re_sq;
    logic [P_W-1:0]      im_sq;
    logic [1:0]          in_flight;
    logic [CNT_W:0]      occupancy;
    logic                accept;
    logic                push;
    logic                pop;

    // Squares are formed at full operand width; the top bit is always zero
    // because the largest square is 2^(2*IN_W-2), so the sum cannot overflow.
    assign re_ext = P_W'($signed(s0_re));
    assign im_ext = P_W'($signed(s0_im));
    assign re_sq  = re_ext * re_ext;
    assign im_sq  = im_ext * im_ext;

    // Readiness counts queued words plus samples still inside the pipeline,
    // so a sample accepted now always finds a free FIFO slot when it lands.
    assign in_flight = {1'b0, s0_valid} + {1'b0, s1_valid};
    assign occupancy = {1'b0, fifo_count} + (CNT_W + 1)'(in_flight);
    assign in_ready  = occupancy < (CNT_W + 1)'(FIFO_DEPTH);

    assign accept = in_valid && in_ready;
    assign push   = s1_valid;
    assign pop    = (state == IDLE) && (fifo_count != '0);

    assign out_idx   = cur_tag;
    assign out_valid = sqrt_done && (state == BUSY);

    // Input capture and squaring stage; the pipeline never stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_valid <= 1'b0;
            s0_re    <= '0;
            s0_im    <= '0;
            s0_idx   <= '0;
            s1_valid <= 1'b0;
            s1_re_sq <= '0;
            s1_im_sq <= '0;
            s1_idx   <= '0;
        end else begin
            s0_valid <= accept;
            if (accept) begin
                s0_re  <= in_re;
                s0_im  <= in_im;
                s0_idx <= in_idx;
            end
            s1_valid <= s0_valid;
            if (s0_valid) begin
                s1_re_sq <= re_sq;
                s1_im_sq <= im_sq;
                s1_idx   <= s0_idx;
            end
        end
    end

    // FIFO storage: the summed power word is written together with its tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_tag[i]  <= '0;
            end
        end else if (push) begin
            fifo_data[wr_ptr] <= s1_re_sq + s1_im_sq;
            fifo_tag[wr_ptr]  <= s1_idx;
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + CNT_W'(1);
            end else if (pop && !push) begin
                fifo_count <= fifo_count - CNT_W'(1);
            end
        end
    end

    // Issue FSM: start the sqrt unit only once the previous job has finished.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sqrt_data  <= '0;
            sqrt_valid <= 1'b0;
            cur_tag    <= '0;
        end else begin
            sqrt_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        sqrt_data  <= fifo_data[rd_ptr];
                        cur_tag    <= fifo_tag[rd_ptr];
                        sqrt_valid <= 1'b1;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (sqrt_done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky flag for samples offered while the block could not take them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop <= 1'b0;
        end else if (in_valid && !in_ready) begin
            drop <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dft_mag_feeder.sv
// Testbench for dft_mag_feeder: a transaction-level model (queue of expected
// power/tag pairs, accepted/issued counts) plus a sqrt-unit stub that answers
// each start pulse with a done pulse after a programmable delay.

module tb_dft_mag_feeder;

    localparam int IN_W  = 16;
    localparam int IDX_W = 10;
    localparam int DEPTH = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [IN_W-1:0]    in_re;
    logic [IN_W-1:0]    in_im;
    logic [IDX_W-1:0]   in_idx;
    logic               in_valid;
    logic               in_ready;
    logic [2*IN_W-1:0]  sqrt_data;
    logic               sqrt_valid;
    logic               sqrt_done;
    logic [IDX_W-1:0]   out_idx;
    logic               out_valid;
    logic               drop;

    dft_mag_feeder #(
        .IN_W       (IN_W),
        .IDX_W      (IDX_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_re      (in_re),
        .in_im      (in_im),
        .in_idx     (in_idx),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sqrt_data  (sqrt_data),
        .sqrt_valid (sqrt_valid),
        .sqrt_done  (sqrt_done),
        .out_idx    (out_idx),
        .out_valid  (out_valid),
        .drop       (drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pw;
        logic [9:0]  idx;
    } exp_t;

    exp_t         exp_q[$];
    int           n_tests = 0;
    int           n_fail = 0;
    int           n_acc = 0;
    int           n_iss = 0;
    bit           outstanding = 0;
    logic [9:0]   cur_tag = '0;
    logic [31:0]  last_data = '0;
    bit           drop_exp = 0;
    bit           ready_exp = 1;
    int           cd = 0;
    int           sqrt_delay = 16;
    bit           rand_delay = 0;
    int           cyc = 0;
    int           acc_cyc = 0;
    bit           lat_armed = 0;
    bit           gap_armed = 0;
    int           last_done_cyc = 0;
    bit           saw_not_ready = 0;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Reference power: plain integer arithmetic on the signed inputs.
    function automatic logic [31:0] powerOf(input logic signed [15:0] r,
                                            input logic signed [15:0] i);
        longint lr;
        longint li;
        lr = r;
        li = i;
        return 32'(lr * lr + li * li);
    endfunction

    // One clock cycle: drive inputs and the sqrt stub, then check after the edge.
    task automatic stepCycle(input bit v, input logic [15:0] re, input logic [15:0] im,
                             input logic [9:0] idx, input bit spur);
        exp_t e;
        cyc++;
        sqrt_done = 1'b0;
        if (cd > 0) begin
            cd--;
            if (cd == 0) sqrt_done = 1'b1;
        end
        if (spur) sqrt_done = 1'b1;
        in_valid = v;
        in_re    = re;
        in_im    = im;
        in_idx   = idx;
        if (v && ready_exp) begin
            exp_q.push_back('{pw: powerOf(re, im), idx: idx});
            n_acc++;
            acc_cyc = cyc;
        end else if (v) begin
            drop_exp = 1;
        end
        #1;
        checkOutput("out_valid", out_valid, sqrt_done && outstanding);
        if (sqrt_done && outstanding) begin
            checkOutput("out_idx_done", out_idx, cur_tag);
            outstanding   = 0;
            last_done_cyc = cyc;
        end
        @(posedge clk);
        @(negedge clk);
        if (!in_ready) saw_not_ready = 1;
        if (sqrt_valid) begin
            checkOutput("issue_while_busy", outstanding, 0);
            checkOutput("issue_has_entry", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("sqrt_data", sqrt_data, e.pw);
                last_data = e.pw;
                cur_tag   = e.idx;
            end
            outstanding = 1;
            n_iss++;
            cd = rand_delay ? int'($urandom_range(2, 12)) : sqrt_delay;
            if (lat_armed) begin
                checkOutput("latency", cyc - acc_cyc, 3);
                lat_armed = 0;
            end
            if (gap_armed) begin
                checkOutput("issue_gap", cyc - last_done_cyc, 1);
                gap_armed = 0;
            end
        end else begin
            checkOutput("sqrt_data_hold", sqrt_data, last_data);
        end
        ready_exp = (n_acc - n_iss) < DEPTH;
        checkOutput("in_ready", in_ready, ready_exp);
        checkOutput("drop", drop, drop_exp);
        checkOutput("out_idx", out_idx, cur_tag);
    endtask

    // Present one sample, waiting (bounded) until the model says it will be taken.
    task automatic applyStimulus(input logic [15:0] re, input logic [15:0] im,
                                 input logic [9:0] idx, input bit arm);
        int guard;
        guard = 0;
        while (!ready_exp && guard < 2000) begin
            stepCycle(0, '0, '0, '0, 0);
            guard++;
        end
        if (!ready_exp) checkOutput("ready_timeout", in_ready, 1);
        lat_armed = arm;
        stepCycle(1, re, im, idx, 0);
    endtask

    // Run idle cycles until every accepted sample has been issued and finished.
    task automatic drainAll();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || outstanding) && guard < 3000) begin
            stepCycle(0, '0, '0, '0, 0);
            guard++;
        end
        checkOutput("drain", exp_q.size() + int'(outstanding), 0);
    endtask

    // Asynchronous reset pulse with an immediate check of all outputs.
    task automatic applyReset();
        in_valid  = 1'b0;
        sqrt_done = 1'b0;
        rst       = 1'b1;
        #1;
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_sqrt_valid", sqrt_valid, 0);
        checkOutput("rst_sqrt_data", sqrt_data, 0);
        checkOutput("rst_out_idx", out_idx, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_drop", drop, 0);
        exp_q.delete();
        n_acc = 0;
        n_iss = 0;
        outstanding = 0;
        cur_tag = '0;
        last_data = '0;
        drop_exp = 0;
        ready_exp = 1;
        cd = 0;
        lat_armed = 0;
        gap_armed = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [15:0] pickVal();
        case ($urandom_range(0, 5))
            0:       return 16'h8000;
            1:       return 16'h7FFF;
            2:       return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_re = '0;
        in_im = '0;
        in_idx = '0;
        sqrt_done = 1'b0;
        #2;
        applyReset();

        // Single sample: 3,4 -> 25, idle latency, tag 7 on done.
        sqrt_delay = 16;
        applyStimulus(16'd3, 16'd4, 10'd7, 1);
        drainAll();

        // Corner values.
        applyStimulus(16'h8000, 16'h8000, 10'd1, 1);
        drainAll();
        applyStimulus(16'h0000, 16'h0000, 10'd2, 0);
        drainAll();
        applyStimulus(16'hFFFF, 16'h7FFF, 10'd3, 0);
        drainAll();

        // Burst of 8 against a slow sqrt: backpressure, strict order, no drops.
        sqrt_delay = 20;
        saw_not_ready = 0;
        for (int k = 0; k < 8; k++) begin
            applyStimulus(16'($urandom), 16'($urandom), 10'(k), 0);
        end
        drainAll();
        checkOutput("burst_backpressure", saw_not_ready, 1);
        checkOutput("burst_no_drop", drop, 0);

        // Spurious done while idle must be ignored.
        stepCycle(0, '0, '0, '0, 1);
        stepCycle(0, '0, '0, '0, 0);

        // Done and FIFO push on the same edge: next issue on the very next cycle.
        sqrt_delay = 8;
        applyStimulus(16'd10, 16'd20, 10'd40, 0);
        for (int g = 0; g < 50 && !outstanding; g++) stepCycle(0, '0, '0, '0, 0);
        for (int k = 0; k < sqrt_delay - 3; k++) stepCycle(0, '0, '0, '0, 0);
        gap_armed = 1;
        stepCycle(1, 16'd7, 16'hFFF0, 10'd41, 0);
        drainAll();

        // Holding in_valid through backpressure sets the sticky drop flag.
        sqrt_delay = 20;
        for (int k = 0; k < 10; k++) begin
            stepCycle(1, 16'($urandom), 16'($urandom), 10'(100 + k), 0);
        end
        drainAll();
        checkOutput("drop_sticky", drop, 1);

        // Reset while busy with three entries queued.
        sqrt_delay = 30;
        for (int k = 0; k < 4; k++) applyStimulus(16'($urandom), 16'($urandom), 10'(200 + k), 0);
        for (int k = 0; k < 6; k++) stepCycle(0, '0, '0, '0, 0);
        checkOutput("pre_rst_queued", exp_q.size(), 3);
        applyReset();
        stepCycle(0, '0, '0, '0, 1);
        sqrt_delay = 5;
        applyStimulus(16'd6, 16'd8, 10'd33, 1);
        checkOutput("fresh_expect_100", exp_q[0].pw, 32'd100);
        drainAll();

        // Randomized traffic with random sqrt latency and occasional spurious dones.
        rand_delay = 1;
        for (int k = 0; k < 600; k++) begin
            bit v;
            bit spur;
            v = ($urandom_range(0, 2) != 0);
            spur = (!outstanding && cd == 0 && $urandom_range(0, 19) == 0);
            stepCycle(v, pickVal(), pickVal(), 10'($urandom), spur);
        end
        rand_delay = 0;
        sqrt_delay = 4;
        drainAll();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dft_mag_feeder.md
Name: dft_mag_feeder

Overview:
- Sits directly upstream of the iterative DFT square-root unit in the magnitude path.
- Accepts a stream of signed complex DFT bins and computes the power re^2 + im^2 in a 2-stage pipeline.
- Buffers the power words with their bin index in a small FIFO. Issues them one at a time to the non-pipelined sqrt unit, starting each only after the previous one finishes.
- Returns the bin index tag aligned with the sqrt done pulse, so downstream can pair result with bin.

Parameters:
IN_W, 16, width of signed re/im inputs; power/sqrt operand width is 2*IN_W (even by construction)
IDX_W, 10, bin index tag width
FIFO_DEPTH, 4, power/tag FIFO entries (power of 2, >=2)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
in_re  in  IN_W  real part, signed two's complement
in_im  in  IN_W  imaginary part, signed
in_idx  in  IDX_W  bin index tag
in_valid  in  1  input sample valid
in_ready  out  1  block can accept a sample this cycle
sqrt_data  out  2*IN_W  unsigned power word to sqrt unit
sqrt_valid  out  1  one-cycle start pulse to sqrt unit
sqrt_done  in  1  sqrt unit finished; its result is valid this cycle
out_idx  out  IDX_W  tag of the sqrt result currently completing
out_valid  out  1  sqrt_done qualified by an outstanding issue
drop  out  1  sticky: a sample was presented while in_ready=0

Behaviour:
- Reset: all registers clear. in_ready=1, sqrt_data=0, sqrt_valid=0, out_idx=0, out_valid=0, drop=0. FIFO is empty, busy=0, in-flight count=0.
- Reset mid-operation aborts everything. A later sqrt_done with busy=0 is ignored: out_valid stays 0.
- Accept: a transfer occurs when in_valid && in_ready at a clock edge (E0).
- Pipeline stage 1 (registered at E1): re*re and im*im, signed, each 2*IN_W-1 bits unsigned.
- Pipeline stage 2 (registered at E2): unsigned sum of the two squares written to the FIFO, together with the index tag that travelled alongside.
- Sum width: the maximum, 2^(2*IN_W-1) for re=im=-2^(IN_W-1), fits in 2*IN_W bits. No saturation is needed.
- Pipeline has no stall. in_flight (0..2) counts accepted samples not yet written to the FIFO.
- in_ready = (fifo_count + in_flight) < FIFO_DEPTH, decoded from registers only, with no combinational path from in_valid.
- in_valid while in_ready=0: the sample is discarded, drop sets and stays set until reset.
- FIFO: circular with wrap-around read/write pointers and a count. Simultaneous push and pop leaves the count unchanged. A push is never lost, because of the in_ready rule.
- Issue FSM, states IDLE and BUSY:
  - IDLE -> BUSY when FIFO is non-empty. In the same edge: pop, load sqrt_data and the current tag register, and assert sqrt_valid for exactly one cycle.
  - BUSY -> IDLE on an edge where sqrt_done=1.
  - The earliest next issue is therefore the cycle after the edge that sampled sqrt_done, so the sqrt unit is never restarted early.
- Idle latency: acceptance at E0 gives a FIFO write at E2 and sqrt_valid high in the cycle after E3.
- sqrt_data holds stable from issue until the next issue.
- out_valid = sqrt_done && busy (combinational). out_idx = current tag register, stable throughout BUSY.
- Ordering: strict FIFO order. Results and tags come back in input order.
- sqrt_done while IDLE is ignored.

Test Plan:
- Single sample re=3, im=4, idx=7, sqrt stub delay 16 cycles -> sqrt_data=25 with one sqrt_valid pulse in the cycle after E3. On the stub's done pulse: out_valid=1, out_idx=7; the real sqrt yields 5.
- Corner re=-32768, im=-32768 -> sqrt_data=0x80000000. re=0, im=0 -> sqrt_data=0. re=-1, im=32767 -> 0x3FFF0002.
- Burst of 8 back-to-back samples, idx 0..7, FIFO_DEPTH=4, slow sqrt -> in_ready deasserts once 4 entries are held or in flight. All 8 are issued and tagged in order 0..7; drop=0; no sqrt_valid while BUSY.
- in_valid held high while in_ready=0 -> drop=1 sticky; the remaining accepted samples still complete correctly.
- Spurious sqrt_done in IDLE -> out_valid=0, no state change. sqrt_done and a FIFO push in the same edge -> the next issue follows on the next cycle; count stays correct.
- rst pulse asserted during BUSY with 3 entries queued -> all outputs return to reset values immediately. A subsequent sqrt_done gives no out_valid. A fresh sample re=6, im=8 then yields sqrt_data=100.
